seg_scan_driver: RTL and testbench

Time-multiplexed scan controller for the board's common-anode seven-segment display, sitting directly upstream of the `seven_seg` hex decoder. Latches a packed multi-digit hex value, walks the digits at a programmable refresh rate, and presents one nibble at a time on `num` for the decoder. It also drives the active-low digit enables and the decimal point. New values are committed only at a frame boundary, so no tearing is visible.

---
 rtl/seg_scan_driver.sv | 92 +++++++++
 tb/tb_seg_scan_driver.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Optional feature macro: SEG_LEAD_ZERO_BLANK_EN (blank leading zero digits).
module seg_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    load,
    output logic                    ack,
    output logic [3:0]              num,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    dp_n
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [DW-1:0]           div_cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] stg_val, shd_val;
    logic [NUM_DIGITS-1:0]   stg_dp, shd_dp;
    logic                    pending;
    logic                    commit_q;

    logic                  tick, wrap, commit, blank;
    logic [NUM_DIGITS-1:0] sel;

    assign tick   = (div_cnt == DIV_LAST);
    assign wrap   = tick && (idx == IDX_LAST);
    assign commit = wrap && pending;

    always_comb begin
        sel = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;
    end

`ifdef SEG_LEAD_ZERO_BLANK_EN
    // Highest nonzero digit; digit 0 always counts so a zero value shows "0".
    logic [IW-1:0] msd;
    always_comb begin
        msd = '0;
        for (int i = 1; i < NUM_DIGITS; i++)
            if (shd_val[4*i +: 4] != 4'h0) msd = IW'(i);
    end
    assign blank = (idx > msd);
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= '0;
            idx      <= '0;
            stg_val  <= '0;
            stg_dp   <= '0;
            shd_val  <= '0;
            shd_dp   <= '0;
            pending  <= 1'b0;
            commit_q <= 1'b0;
            ack      <= 1'b0;
            num      <= 4'h0;
            digit_en <= '1;
            dp_n     <= 1'b1;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) idx <= wrap ? '0 : idx + 1'b1;

            if (commit) begin
                shd_val <= stg_val;
                shd_dp  <= stg_dp;
                pending <= 1'b0;
            end
            // A load on the commit cycle stages for the following frame.
            if (load) begin
                stg_val <= value;
                stg_dp  <= dp_mask;
                pending <= 1'b1;
            end

            // ack lines up with the first output cycle showing the new value.
            commit_q <= commit;
            ack      <= commit_q;

            num      <= shd_val[4*idx +: 4];
            digit_en <= blank ? '1 : ~sel;
            dp_n     <= blank | ~shd_dp[idx];
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver with NUM_DIGITS=4, CLK_DIV=4.
module tb_seg_scan_driver;
    localparam int ND = 4;
    localparam int CD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp_mask = '0;
    logic        load = 1'b0;
    logic        ack;
    logic [3:0]  num;
    logic [3:0]  digit_en;
    logic        dp_n;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] v;
        logic [3:0]  dp;
    } exp_t;
    exp_t sb[$];

    seg_scan_driver #(.NUM_DIGITS(ND), .CLK_DIV(CD)) dut (
        .clk(clk), .rst(rst), .value(value), .dp_mask(dp_mask), .load(load),
        .ack(ack), .num(num), .digit_en(digit_en), .dp_n(dp_n)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a one-cycle load; optionally record the value expected to be committed.
    task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input bit push);
        value = v; dp_mask = dp; load = 1'b1;
        if (push) sb.push_back({v, dp});
        @(negedge clk);
        load = 1'b0; value = 16'($urandom); dp_mask = 4'($urandom);
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        while (ack !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (ack !== 1'b1) begin
            checks++; errors++;
            $display("FAIL ack_timeout: got no ack within %0d cycles", n);
            n = -1;
        end
    endtask

    task automatic sync_frame_start();
        logic [3:0] prev;
        int n = 0;
        prev = digit_en;
        @(negedge clk);
        while (!(digit_en === 4'b1110 && prev !== 4'b1110) && n < 100) begin
            prev = digit_en;
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL frame_sync: got digit_en %b, want 1110", digit_en);
        end
    endtask

    // Check one full frame starting at the current sample (slot 0, cycle 0).
    task automatic check_frame(input logic [15:0] v, input logic [3:0] dp,
                               input logic exp_ack, input string tag);
        int d;
        logic blank, e_dp, e_ack;
        logic [3:0] e_en;
`ifdef SEG_LEAD_ZERO_BLANK_EN
        int msd = 0;
        for (int i = 1; i < ND; i++) if (v[4*i +: 4] != 4'h0) msd = i;
`endif
        for (int c = 0; c < ND*CD; c++) begin
            if (c > 0) @(negedge clk);
            d = c / CD;
`ifdef SEG_LEAD_ZERO_BLANK_EN
            blank = (d > msd);
`else
            blank = 1'b0;
`endif
            e_en  = blank ? 4'hF : ~(4'b0001 << d);
            e_dp  = blank ? 1'b1 : ~dp[d];
            e_ack = (c == 0) ? exp_ack : 1'b0;
            checks++;
            if (digit_en !== e_en) begin
                errors++;
                $display("FAIL %s digit_en cyc %0d: got %b want %b", tag, c, digit_en, e_en);
            end
            checks++;
            if (dp_n !== e_dp) begin
                errors++;
                $display("FAIL %s dp_n cyc %0d: got %b want %b", tag, c, dp_n, e_dp);
            end
            checks++;
            if (ack !== e_ack) begin
                errors++;
                $display("FAIL %s ack cyc %0d: got %b want %b", tag, c, ack, e_ack);
            end
            if (!blank) begin
                checks++;
                if (num !== v[4*d +: 4]) begin
                    errors++;
                    $display("FAIL %s num cyc %0d: got %h want %h", tag, c, num, v[4*d +: 4]);
                end
            end
        end
    endtask

    task automatic expect_ack_after(input int want, input string tag);
        int n;
        exp_t e;
        wait_ack(n);
        if (n < 0) return;
        checks++;
        if (n != want) begin
            errors++;
            $display("FAIL %s ack_latency: got %0d want %0d", tag, n, want);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: got empty queue want an entry", tag);
        end else begin
            e = sb.pop_front();
            check_frame(e.v, e.dp, 1'b1, tag);
        end
    endtask

    task automatic test_reset();
        logic [3:0] e_en;
        rst = 1'b1;
        tick(3);
        checks += 4;
        if (digit_en !== 4'hF) begin errors++; $display("FAIL rst digit_en: got %b want 1111", digit_en); end
        if (dp_n !== 1'b1)     begin errors++; $display("FAIL rst dp_n: got %b want 1", dp_n); end
        if (num !== 4'h0)      begin errors++; $display("FAIL rst num: got %h want 0", num); end
        if (ack !== 1'b0)      begin errors++; $display("FAIL rst ack: got %b want 0", ack); end
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            e_en = ~(4'b0001 << ((k / CD) % ND));
            checks += 2;
            if (digit_en !== e_en) begin
                errors++; $display("FAIL scan digit_en k=%0d: got %b want %b", k, digit_en, e_en);
            end
            if (num !== 4'h0) begin
                errors++; $display("FAIL scan num k=%0d: got %h want 0", k, num);
            end
        end
    endtask

    task automatic test_load_basic();
        sync_frame_start();
        tick(5);
        do_load(16'hA5C3, 4'b0100, 1'b1);
        expect_ack_after(10, "basic");
    endtask

    task automatic test_double_load();
        sync_frame_start();
        tick(2);
        do_load(16'h1111, 4'b0000, 1'b0);
        tick(3);
        do_load(16'h2222, 4'b0011, 1'b1);
        expect_ack_after(9, "double");
    endtask

    task automatic test_back_to_back();
        sync_frame_start();
        tick(3);
        do_load(16'h1234, 4'b0001, 1'b1);
        tick(10);
        do_load(16'h5678, 4'b1000, 1'b1);   // sampled on the commit edge
        expect_ack_after(1, "b2b_first");
        expect_ack_after(1, "b2b_second");
    endtask

    task automatic test_reset_pending();
        int seen = 0;
        sync_frame_start();
        tick(1);
        do_load(16'h9ABC, 4'b1111, 1'b0);
        tick(7);                            // idx == 2 here
        rst = 1'b1;
        tick(1);
        checks += 4;
        if (digit_en !== 4'hF) begin errors++; $display("FAIL rstp digit_en: got %b want 1111", digit_en); end
        if (dp_n !== 1'b1)     begin errors++; $display("FAIL rstp dp_n: got %b want 1", dp_n); end
        if (num !== 4'h0)      begin errors++; $display("FAIL rstp num: got %h want 0", num); end
        if (ack !== 1'b0)      begin errors++; $display("FAIL rstp ack: got %b want 0", ack); end
        rst = 1'b0;
        tick(1);
        check_frame(16'h0000, 4'b0000, 1'b0, "rstp_frame");
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ack === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rstp no_ack: got %0d acks want 0", seen); end
    endtask

    task automatic test_blank();
        sync_frame_start();
        tick(2);
        do_load(16'h0070, 4'b1100, 1'b1);
        expect_ack_after(13, "blank_0070");
        do_load(16'h0000, 4'b0010, 1'b1);
        expect_ack_after(16, "blank_0000");
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_double_load();
        test_back_to_back();
        test_reset_pending();
        test_blank();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
